// File: rtl/serial_adder.sv
// serial_adder: bit-serial add/subtract, one result bit per clock, LSB first.
module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);
   localparam int CW = $clog2(WIDTH);
   typedef enum logic {IDLE, RUN} state_t;
   state_t state, state_nx;
   logic [CW-1:0] cnt;
   logic [WIDTH-1:0] x, y, r;
   logic c, sm, s, c_nx, last;
   always_comb begin
      s        = x[0] ^ y[0] ^ c;
      c_nx     = (x[0] & y[0]) | (x[0] & c) | (y[0] & c);
      last     = cnt == CW'(WIDTH - 1);
      state_nx = state == IDLE ? (start ? RUN : IDLE) : (last ? IDLE : RUN);
   end
   assign busy = state == RUN;
   always_ff @(posedge clk)
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt  <= '0;
         x    <= '0;
         y    <= '0;
         r    <= '0;
         c    <= 1'b0;
         sm   <= 1'b0;
         done <= 1'b0;
         sum  <= '0;
         cout <= 1'b0;
         ovf  <= 1'b0;
      end else begin
         done <= 1'b0;
         if (state == IDLE) begin
            if (start) begin
               // subtraction runs as a + ~b + ~cin
               x   <= a;
               y   <= b ^ {WIDTH{sub}};
               c   <= cin ^ sub;
               sm  <= sub;
               cnt <= '0;
            end
         end else begin
            x   <= x >> 1;
            y   <= y >> 1;
            c   <= c_nx;
            r   <= {s, r[WIDTH-1:1]};
            cnt <= cnt + CW'(1);
            if (last) begin
               sum  <= {s, r[WIDTH-1:1]};
               cout <= c_nx ^ sm;
               ovf  <= c ^ c_nx;
               done <= 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed vector table plus hand-written reset/overlap sequences.
module tb_serial_adder;
   logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, sub = 1'b0, cin = 1'b0;
   logic [7:0] a = '0, b = '0;
   logic busy, done, cout, ovf;
   logic [7:0] sum;
   int n_cmp = 0, n_bad = 0;

   serial_adder #(.WIDTH(8)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b), .cin(cin),
      .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       s;
      logic [7:0] a;
      logic [7:0] b;
      logic       ci;
      logic [7:0] es;
      logic       ec;
      logic       eo;
      int         inj;
   } vec_t;
   vec_t tv[8];

   task automatic chk(input string nm, input longint act, input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic op(input vec_t v, output int lat, output int bc, output int hb);
      logic [7:0] hs;
      logic hc, ho;
      hs = sum; hc = cout; ho = ovf;
      @(negedge clk);
      sub = v.s; a = v.a; b = v.b; cin = v.ci; start = 1'b1;
      @(posedge clk);
      lat = -1; bc = 0; hb = 0;
      for (int i = 1; i <= 20 && lat < 0; i++) begin
         @(negedge clk);
         if (i == 1) start = 1'b0;
         if (i == v.inj) begin
            start = 1'b1; a = 8'hAA; b = 8'h55; cin = 1'b1; sub = ~v.s;
         end
         if (i == v.inj + 1) start = 1'b0;
         if (done) begin
            lat = i - 1;
            chk("busy_at_done", busy, 0);
         end else begin
            if (busy) bc++;
            if (sum !== hs || cout !== hc || ovf !== ho) hb++;
         end
      end
      start = 1'b0;
      @(negedge clk);
      chk("done_one_cycle", done, 0);
   endtask

   initial begin
      int lat, bc, hb, d1, d2, nd;
      logic [7:0] s1, s2;
      tv[0] = '{1'b0, 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1, 0};
      tv[1] = '{1'b0, 8'hFF, 8'h01, 1'b1, 8'h01, 1'b1, 1'b0, 0};
      tv[2] = '{1'b1, 8'h10, 8'h20, 1'b0, 8'hF0, 1'b1, 1'b0, 0};
      tv[3] = '{1'b1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 0};
      tv[4] = '{1'b1, 8'h05, 8'h03, 1'b1, 8'h01, 1'b0, 1'b0, 0};
      tv[5] = '{1'b0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 0};
      tv[6] = '{1'b1, 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 0};
      tv[7] = '{1'b0, 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1, 3};
      // start asserted during reset must not be taken
      @(negedge clk); start = 1'b1; a = 8'h11; b = 8'h22;
      @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_sum", sum, 0);
      chk("rst_cout", cout, 0);
      chk("rst_ovf", ovf, 0);
      start = 1'b0; rst_n = 1'b1;
      @(negedge clk);
      chk("idle_busy", busy, 0);
      for (int k = 0; k < 8; k++) begin
         op(tv[k], lat, bc, hb);
         chk($sformatf("v%0d_latency", k), lat, 8);
         chk($sformatf("v%0d_busy_cycles", k), bc, 8);
         chk($sformatf("v%0d_hold", k), hb, 0);
         chk($sformatf("v%0d_sum", k), sum, tv[k].es);
         chk($sformatf("v%0d_cout", k), cout, tv[k].ec);
         chk($sformatf("v%0d_ovf", k), ovf, tv[k].eo);
      end
      // reset sampled on the edge that would compute bit 4
      @(negedge clk); sub = 1'b0; a = 8'hFF; b = 8'h01; cin = 1'b1; start = 1'b1;
      @(posedge clk);
      nd = 0;
      for (int i = 1; i <= 15; i++) begin
         @(negedge clk);
         if (i == 1) start = 1'b0;
         if (i == 5) rst_n = 1'b0;
         if (i == 6) begin
            rst_n = 1'b1;
            chk("abort_busy", busy, 0);
            chk("abort_sum", sum, 0);
            chk("abort_cout", cout, 0);
            chk("abort_ovf", ovf, 0);
         end
         if (done) nd++;
      end
      chk("abort_no_done", nd, 0);
      op(tv[1], lat, bc, hb);
      chk("post_abort_latency", lat, 8);
      chk("post_abort_sum", sum, 8'h01);
      chk("post_abort_cout", cout, 1);
      // start held high: back-to-back operations
      @(negedge clk); sub = 1'b0; a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1;
      @(posedge clk);
      d1 = -1; d2 = -1; s1 = '0; s2 = '0;
      for (int i = 1; i <= 30; i++) begin
         @(negedge clk);
         if (i == 1) begin a = 8'h02; b = 8'h02; end
         if (done && d1 < 0) begin d1 = i; s1 = sum; end
         else if (done && d2 < 0) begin d2 = i; s2 = sum; start = 1'b0; end
      end
      chk("b2b_first_latency", d1, 9);
      chk("b2b_spacing", d2 - d1, 9);
      chk("b2b_sum1", s1, 8'h02);
      chk("b2b_sum2", s2, 8'h04);
      chk("b2b_idle_end", busy, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
